// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one external combinational FP adder among N requesters.
// One operation in flight at a time; result returned on a valid/ready channel with the owner ID.
module fp_add_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned IDW     = $clog2(N)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N-1:0]      i_req_valid,
  output logic [N-1:0]      o_req_ready,
  input  logic [32*N-1:0]   i_req_a,
  input  logic [32*N-1:0]   i_req_b,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [IDW-1:0]    o_rsp_id,
  output logic [31:0]       o_rsp_result,
  output logic              o_rsp_overflow,
  output logic              o_rsp_underflow,
  output logic [31:0]       o_add_a,
  output logic [31:0]       o_add_b,
  input  logic [31:0]       i_add_result,
  input  logic              i_add_overflow,
  input  logic              i_add_underflow
);

  localparam int unsigned CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          r_state, w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [IDW-1:0]  r_gnt_id, w_gnt_id_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [31:0]     r_add_a, w_add_a_nxt;
  logic [31:0]     r_add_b, w_add_b_nxt;
  logic            r_rsp_valid, w_rsp_valid_nxt;
  logic [IDW-1:0]  r_rsp_id, w_rsp_id_nxt;
  logic [31:0]     r_rsp_result, w_rsp_result_nxt;
  logic            r_rsp_ovf, w_rsp_ovf_nxt;
  logic            r_rsp_unf, w_rsp_unf_nxt;

  logic            w_gnt_valid;
  logic [IDW-1:0]  w_gnt_id;
  logic [IDW-1:0]  w_idx;

  // First valid requester at or after the round-robin pointer, wrapping mod N.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_id    = '0;
    w_idx       = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % int'(N));
      if (!w_gnt_valid && i_req_valid[w_idx]) begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_gnt_id_nxt     = r_gnt_id;
    w_cnt_nxt        = r_cnt;
    w_add_a_nxt      = r_add_a;
    w_add_b_nxt      = r_add_b;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_id_nxt     = r_rsp_id;
    w_rsp_result_nxt = r_rsp_result;
    w_rsp_ovf_nxt    = r_rsp_ovf;
    w_rsp_unf_nxt    = r_rsp_unf;
    o_req_ready      = '0;
    unique case (r_state)
      StIdle: begin
        if (w_gnt_valid) begin
          o_req_ready[w_gnt_id] = 1'b1;
          w_add_a_nxt           = i_req_a[32*w_gnt_id +: 32];
          w_add_b_nxt           = i_req_b[32*w_gnt_id +: 32];
          w_gnt_id_nxt          = w_gnt_id;
          w_cnt_nxt             = CW'(ADD_LAT - 1);
          w_state_nxt           = StExec;
        end
      end
      StExec: begin
        if (r_cnt == '0) begin
          w_rsp_result_nxt = i_add_result;
          w_rsp_ovf_nxt    = i_add_overflow;
          w_rsp_unf_nxt    = i_add_underflow;
          w_rsp_id_nxt     = r_gnt_id;
          w_rsp_valid_nxt  = 1'b1;
          w_rr_ptr_nxt     = IDW'((int'(r_gnt_id) + 1) % int'(N));
          w_state_nxt      = StResp;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      StResp: begin
        if (i_rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_rr_ptr     <= '0;
      r_gnt_id     <= '0;
      r_cnt        <= '0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_unf    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_gnt_id     <= w_gnt_id_nxt;
      r_cnt        <= w_cnt_nxt;
      r_add_a      <= w_add_a_nxt;
      r_add_b      <= w_add_b_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_id     <= w_rsp_id_nxt;
      r_rsp_result <= w_rsp_result_nxt;
      r_rsp_ovf    <= w_rsp_ovf_nxt;
      r_rsp_unf    <= w_rsp_unf_nxt;
    end
  end

  assign o_add_a         = r_add_a;
  assign o_add_b         = r_add_b;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_id        = r_rsp_id;
  assign o_rsp_result    = r_rsp_result;
  assign o_rsp_overflow  = r_rsp_ovf;
  assign o_rsp_underflow = r_rsp_unf;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: stub adder, round-robin reference model, directed + random ops.
// A second instance built with ADD_LAT=3 covers the retimed-adder latency.
module tb_fp_add_arbiter;

  localparam int unsigned LAT1 = 1;
  localparam int unsigned LAT3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic         rsp_valid, rsp_ready, rsp_ovf, rsp_unf;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result, add_a, add_b, add_res;
  logic         add_ovf, add_unf;

  logic [3:0]   s_req_valid, s_req_ready;
  logic [127:0] s_req_a, s_req_b;
  logic         s_rsp_valid, s_rsp_ready, s_rsp_ovf, s_rsp_unf;
  logic [1:0]   s_rsp_id;
  logic [31:0]  s_rsp_result, s_add_a, s_add_b, s_add_res;
  logic         s_add_ovf, s_add_unf;

  // Adder stand-in: exact IEEE results for the directed cases, an arbitrary fixed function otherwise.
  function automatic logic [33:0] mock_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return {2'b00, 32'h4040_0000};
    if (a == 32'h3F80_0000 && b == 32'h3F80_0000) return {2'b00, 32'h4000_0000};
    if (a == 32'h7F00_0000 && b == 32'h7F00_0000) return {2'b10, 32'h7F80_0000};
    return {^a, ^b, a + b};
  endfunction

  always_comb {add_ovf, add_unf, add_res} = mock_add(add_a, add_b);
  always_comb {s_add_ovf, s_add_unf, s_add_res} = mock_add(s_add_a, s_add_b);

  fp_add_arbiter #(.N(4), .ADD_LAT(LAT1), .IDW(2)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_a(req_a), .i_req_b(req_b),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_result(rsp_result), .o_rsp_overflow(rsp_ovf), .o_rsp_underflow(rsp_unf),
    .o_add_a(add_a), .o_add_b(add_b),
    .i_add_result(add_res), .i_add_overflow(add_ovf), .i_add_underflow(add_unf)
  );

  fp_add_arbiter #(.N(4), .ADD_LAT(LAT3), .IDW(2)) u_dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(s_req_valid), .o_req_ready(s_req_ready), .i_req_a(s_req_a), .i_req_b(s_req_b),
    .o_rsp_valid(s_rsp_valid), .i_rsp_ready(s_rsp_ready), .o_rsp_id(s_rsp_id),
    .o_rsp_result(s_rsp_result), .o_rsp_overflow(s_rsp_ovf), .o_rsp_underflow(s_rsp_unf),
    .o_add_a(s_add_a), .o_add_b(s_add_b),
    .i_add_result(s_add_res), .i_add_overflow(s_add_ovf), .i_add_underflow(s_add_unf)
  );

  int          total = 0;
  int          bad = 0;
  int          ptr_m = 0;
  int          gnt_cyc = 0;
  logic [31:0] opa [4];
  logic [31:0] opb [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++)
      if (((m >> ((p + k) % 4)) & 4'd1) != 4'd0) return (p + k) % 4;
    return -1;
  endfunction

  // One full transaction on the ADD_LAT=1 instance; caller guarantees the DUT is idle.
  task automatic do_op(input logic [3:0] vmask, input int stall);
    int          g;
    int          lat;
    logic [33:0] e;
    g = pick(vmask, ptr_m);
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = opa[i];
      req_b[32*i +: 32] = opb[i];
    end
    req_valid = vmask;
    rsp_ready = (stall == 0);
    #1;
    chk("grant", 32'(req_ready), 32'(4'b0001 << g));
    gnt_cyc = cyc;
    e = mock_add(opa[g], opb[g]);
    @(negedge clk);
    req_valid[g] = 1'b0;
    req_a[32*g +: 32] = ~opa[g];
    #1;
    chk("exec_ready", 32'(req_ready), 32'd0);
    chk("add_a", add_a, opa[g]);
    chk("add_b", add_b, opb[g]);
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(LAT1 + 1));
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_result", rsp_result, e[31:0]);
    chk("rsp_flags", 32'({rsp_ovf, rsp_unf}), 32'(e[33:32]));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_result", rsp_result, e[31:0]);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    ptr_m = (g + 1) % 4;
  endtask

  initial begin
    int prev;
    int lat;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    s_req_valid = '0; s_req_a = '0; s_req_b = '0; s_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      opa[i] = $urandom;
      opb[i] = $urandom;
    end
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_flags", 32'({rsp_ovf, rsp_unf}), 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1.0 + 2.0 from requester 0
    opa[0] = 32'h3F80_0000; opb[0] = 32'h4000_0000;
    do_op(4'b0001, 0);

    // all requesting, back-to-back: rotating order, fixed issue interval
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 4; i++) begin
        opa[i] = $urandom;
        opb[i] = $urandom;
      end
      prev = gnt_cyc;
      do_op(4'b1111, 0);
      if (n > 0) chk("interval", 32'(gnt_cyc - prev), 32'(LAT1 + 2));
    end

    // consumer back-pressure with others waiting
    do_op(4'b1111, 5);

    // overflow pass-through from requester 2
    opa[2] = 32'h7F00_0000; opb[2] = 32'h7F00_0000;
    do_op(4'b0100, 0);

    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 4; i++) begin
        opa[i] = $urandom;
        opb[i] = $urandom;
      end
      do_op(4'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
    end

    // reset mid-EXEC: pointer moved to 2 first so a stale pointer would pick 3 below
    opa[2] = 32'h1234_5678;
    do_op(4'b0010, 0);
    req_valid = 4'b1111;
    #1;
    chk("abort_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("abort_add_a", add_a, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    rst = 1'b0;
    ptr_m = 0;
    @(negedge clk);
    chk("post_abort_valid", 32'(rsp_valid), 32'd0);
    do_op(4'b1010, 0);
    do_op(4'b1000, 0);

    // ADD_LAT=3 instance: 1.0 + 1.0 from requester 1
    s_req_a[63:32] = 32'h3F80_0000;
    s_req_b[63:32] = 32'h3F80_0000;
    s_req_valid = 4'b0010;
    #1;
    chk("lat3_grant", 32'(s_req_ready), 32'b0010);
    @(negedge clk);
    s_req_valid = '0;
    lat = 1;
    while (!s_rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("lat3_latency", 32'(lat), 32'(LAT3 + 1));
    chk("lat3_result", s_rsp_result, 32'h4000_0000);
    chk("lat3_id", 32'(s_rsp_id), 32'd1);
    @(negedge clk);
    chk("lat3_drop", 32'(s_rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
